an_tx_tone_src: RTL and testbench

Audio sample source directly upstream of the AN_TX modulator.
- Generates a fixed-frequency sine tone from a phase accumulator and a quarter-wave LUT, at a sample strobe divided down from the system clock.
- A debounced push-key toggles the tone on and off, with a linear fade envelope so toggling does not click.
- Samples are delivered over a valid/ready handshake into the modulator's audio input.

---
 rtl/an_tx_pkg.sv | 34 +++
 rtl/an_tx_qsin_rom.sv | 37 +++
 rtl/an_tx_tone_src.sv | 200 ++++++++++++++++++++
 tb/tb_an_tx_tone_src.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/an_tx_pkg.sv
// rtl/an_tx_pkg.sv - shared state encoding, elaboration helpers and probe-bus field map for the tone source
package an_tx_pkg;

  typedef enum logic [1:0] {
    S_MUTE = 2'd0,
    S_UP   = 2'd1,
    S_PLAY = 2'd2,
    S_DN   = 2'd3
  } state_t;

  localparam int DBG_PH_LSB  = 24;
  localparam int DBG_ENV_LSB = 15;
  localparam int DBG_ST_LSB  = 13;
  localparam int DBG_OVR_BIT = 12;
  localparam int DBG_KEY_BIT = 11;

  // ceil(log2(v)); exact for powers of two
  function automatic int log2(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint ftw_calc(input longint tone, input longint smpl, input int pw);
    return (tone * (longint'(1) << pw) * 2 + smpl) / (2 * smpl);
  endfunction

endpackage

// File: rtl/an_tx_qsin_rom.sv
// rtl/an_tx_qsin_rom.sv - registered quarter-wave sine magnitude ROM, one clock of latency
module an_tx_qsin_rom #(
  parameter int C_AW = 8,
  parameter int C_DW = 16
) (
  input  logic            i_clk,
  input  logic [C_AW-1:0] i_addr,
  output logic [C_DW-1:0] o_data
);

  // Taylor series keeps table generation a pure constant function
  function automatic int qsin_val(input int i);
    real x;
    real t;
    real s;
    x = (real'(i) + 0.5) * 3.14159265358979323846 / real'(2 ** (C_AW + 1));
    t = x;
    s = x;
    for (int k = 1; k < 10; k++) begin
      t = -t * x * x / real'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return $rtoi(s * real'((2 ** (C_DW - 1)) - 1) + 0.5);
  endfunction

  logic [C_DW-1:0] w_lut [2**C_AW];

  for (genvar g = 0; g < 2**C_AW; g++) begin : g_lut
    localparam logic [C_DW-1:0] C_V = C_DW'(qsin_val(g));
    assign w_lut[g] = C_V;
  end

  always_ff @(posedge i_clk) begin
    o_data <= w_lut[i_addr];
  end

endmodule

// File: rtl/an_tx_tone_src.sv
// rtl/an_tx_tone_src.sv - key-toggled faded sine tone source feeding the AN_TX modulator
// Define AN_TX_TONE_SRC_DBG_EN to add the registered DBG_o probe bus.
module an_tx_tone_src
  import an_tx_pkg::*;
#(
  parameter int C_CK_Fs      = 135_000_000,
  parameter int C_SMPL_Fs    = 48_000,
  parameter int C_TONE_Fs    = 440,
  parameter int C_PHASE_W    = 24,
  parameter int C_DAT_W      = 16,
  parameter int C_LUT_AW     = 8,
  parameter int C_RAMP_SMPLs = 256,
  parameter int C_DEB_CKNs   = 1_048_576
) (
  input  logic                      CK_i,
  input  logic                      XSRST_i,
  input  logic                      XKEY_i,
  output logic signed [C_DAT_W-1:0] SMPL_o,
  output logic                      SMPL_VALID_o,
  input  logic                      SMPL_READY_i,
  output logic                      PLAYING_o,
  output logic                      OVERRUN_o,
  output logic                      KEY_PRESS_o
`ifdef AN_TX_TONE_SRC_DBG_EN
  ,
  output logic [31:0]               DBG_o
`endif
);

  localparam int C_DIV   = C_CK_Fs / C_SMPL_Fs;
  localparam int C_DIV_W = (log2(C_DIV) < 1) ? 1 : log2(C_DIV);
  localparam int C_SH    = log2(C_RAMP_SMPLs);
  localparam int C_ENV_W = C_SH + 1;
  localparam int C_DEB_W = (log2(C_DEB_CKNs) < 1) ? 1 : log2(C_DEB_CKNs);
  localparam int C_PRD_W = C_DAT_W + C_ENV_W + 1;
  localparam logic [C_PHASE_W-1:0] C_FTW = C_PHASE_W'(ftw_calc(C_TONE_Fs, C_SMPL_Fs, C_PHASE_W));

  logic [C_DIV_W-1:0]       r_div;
  logic [C_PHASE_W-1:0]     r_phase;
  logic [C_ENV_W-1:0]       r_env, w_env_nx;
  state_t                   r_state, w_state_nx;
  logic                     r_s1, r_s2, r_deb, r_press, r_pend;
  logic [C_DEB_W-1:0]       r_deb_cnt;
  logic                     r_p1, r_p2, r_neg;
  logic                     r_valid, r_ovr;
  logic signed [C_DAT_W-1:0] r_smpl;
  logic                     w_stb, w_press_any;
  logic [1:0]               w_quad;
  logic [C_LUT_AW-1:0]      w_idx;
  logic [C_DAT_W-1:0]       w_rom_q;
  logic signed [C_DAT_W-1:0] w_sin, w_smpl;
  logic signed [C_PRD_W-1:0] w_prod;

  assign w_stb       = (r_div == C_DIV_W'(C_DIV - 1));
  assign w_press_any = r_pend | r_press;

  // a level change is accepted only after it has held for C_DEB_CKNs clocks
  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_deb     <= 1'b1;
      r_deb_cnt <= '0;
      r_press   <= 1'b0;
    end else begin
      r_s1    <= XKEY_i;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == C_DEB_W'(C_DEB_CKNs - 1)) begin
        r_deb     <= r_s2;
        r_deb_cnt <= '0;
        r_press   <= r_deb;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      r_div   <= '0;
      r_phase <= '0;
      r_pend  <= 1'b0;
      r_p1    <= 1'b0;
      r_p2    <= 1'b0;
      r_neg   <= 1'b0;
      r_state <= S_MUTE;
      r_env   <= '0;
    end else begin
      r_div   <= w_stb ? '0 : r_div + 1'b1;
      r_p1    <= w_stb;
      r_p2    <= r_p1;
      r_neg   <= w_quad[1];
      r_state <= w_state_nx;
      r_env   <= w_env_nx;
      if (w_stb) begin
        r_phase <= r_phase + C_FTW;
        r_pend  <= 1'b0;
      end else if (r_press) begin
        r_pend  <= 1'b1;
      end
    end
  end

  // a pending press always wins over reaching a ramp endpoint
  always_comb begin
    w_state_nx = r_state;
    w_env_nx   = r_env;
    if (w_stb) begin
      case (r_state)
        S_MUTE: begin
          w_env_nx = '0;
          if (w_press_any) w_state_nx = S_UP;
        end
        S_UP: begin
          if (w_press_any) begin
            w_state_nx = S_DN;
          end else begin
            w_env_nx = r_env + 1'b1;
            if (r_env == C_ENV_W'(C_RAMP_SMPLs - 1)) w_state_nx = S_PLAY;
          end
        end
        S_PLAY: begin
          w_env_nx = C_ENV_W'(C_RAMP_SMPLs);
          if (w_press_any) w_state_nx = S_DN;
        end
        default: begin
          if (w_press_any) begin
            w_state_nx = S_UP;
          end else if (r_env <= C_ENV_W'(1)) begin
            w_env_nx   = '0;
            w_state_nx = S_MUTE;
          end else begin
            w_env_nx = r_env - 1'b1;
          end
        end
      endcase
    end
  end

  assign w_quad = r_phase[C_PHASE_W-1 -: 2];
  assign w_idx  = r_phase[C_PHASE_W-3 -: C_LUT_AW] ^ {C_LUT_AW{w_quad[0]}};

  an_tx_qsin_rom #(
    .C_AW (C_LUT_AW),
    .C_DW (C_DAT_W)
  ) u_rom (
    .i_clk  (CK_i),
    .i_addr (w_idx),
    .o_data (w_rom_q)
  );

  assign w_sin  = r_neg ? -$signed(w_rom_q) : $signed(w_rom_q);
  assign w_prod = $signed({{(C_ENV_W + 1){w_sin[C_DAT_W-1]}}, w_sin})
                * $signed({{(C_DAT_W + 1){1'b0}}, r_env});
  assign w_smpl = C_DAT_W'(w_prod >>> C_SH);

  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      r_smpl  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_p2) begin
      if (!r_valid || SMPL_READY_i) begin
        r_smpl  <= w_smpl;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && SMPL_READY_i) begin
      r_valid <= 1'b0;
    end
  end

  assign SMPL_o       = r_smpl;
  assign SMPL_VALID_o = r_valid;
  assign OVERRUN_o    = r_ovr;
  assign KEY_PRESS_o  = r_press;
  assign PLAYING_o    = (r_state != S_MUTE);

`ifdef AN_TX_TONE_SRC_DBG_EN
  logic [31:0] r_dbg;
  always_ff @(posedge CK_i) begin
    if (!XSRST_i) begin
      r_dbg <= '0;
    end else begin
      r_dbg                         <= '0;
      r_dbg[DBG_PH_LSB +: 8]        <= r_phase[C_PHASE_W-1 -: 8];
      r_dbg[DBG_ENV_LSB +: C_ENV_W] <= r_env;
      r_dbg[DBG_ST_LSB +: 2]        <= r_state;
      r_dbg[DBG_OVR_BIT]            <= r_ovr;
      r_dbg[DBG_KEY_BIT]            <= r_deb;
    end
  end
  assign DBG_o = r_dbg;
`endif

endmodule

// File: tb/tb_an_tx_tone_src.sv
// tb/tb_an_tx_tone_src.sv - scoreboard bench for an_tx_tone_src at an 8-clock sample period
module tb_an_tx_tone_src;

  localparam int DIV  = 8;
  localparam int RAMP = 256;
  localparam int FTW  = 153791;
  localparam int PMOD = 1 << 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic key = 1'b1;
  logic ready = 1'b1;
  logic signed [15:0] smpl;
  logic valid, playing, ovr, kp;
`ifdef AN_TX_TONE_SRC_DBG_EN
  logic [31:0] dbg;
`endif

  always #5 clk = ~clk;

  an_tx_tone_src #(
    .C_CK_Fs    (48000 * DIV),
    .C_DEB_CKNs (16)
  ) dut (
    .CK_i         (clk),
    .XSRST_i      (rstn),
    .XKEY_i       (key),
    .SMPL_o       (smpl),
    .SMPL_VALID_o (valid),
    .SMPL_READY_i (ready),
    .PLAYING_o    (playing),
    .OVERRUN_o    (ovr),
    .KEY_PRESS_o  (kp)
`ifdef AN_TX_TONE_SRC_DBG_EN
    ,
    .DBG_o        (dbg)
`endif
  );

  typedef struct { int val; int ph; } exp_t;
  typedef struct { int low_clks; int exp_press; } deb_vec_t;

  int total = 0;
  int bad = 0;
  int lut [256];
  exp_t exp_q [$];

  int   m_div, m_phase, m_env, m_st, m_pend, m_p1, m_p2, m_valid, m_ovr;
  exp_t m_v1, m_v2;
  logic s_valid = 1'b0;
  logic s_kp = 1'b0;
  logic signed [15:0] s_smpl = '0;
  int   n_kp, last_ph;
  bit   track;
  int   n_win, pk_d, pk_e, zc_d, zc_e, sg_d, sg_e;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int ref_val(input int ph, input int env);
    int q, idx, s;
    q   = (ph >> 22) & 3;
    idx = (ph >> 14) & 255;
    if (q & 1) idx = 255 - idx;
    s = lut[idx];
    if (q & 2) s = -s;
    return (s * env) >>> 8;
  endfunction

  task automatic track_one(input int v, inout int pk, inout int zc, inout int sg);
    int a, n;
    a = (v < 0) ? -v : v;
    if (a > pk) pk = a;
    if (v != 0) begin
      n = (v > 0) ? 1 : -1;
      if (sg != 0 && n != sg) zc++;
      sg = n;
    end
  endtask

  task automatic tick();
    bit   stb, m_acc;
    int   pa;
    exp_t e;
    @(posedge clk);
    if (!rstn) begin
      m_div = 0; m_phase = 0; m_env = 0; m_st = 0; m_pend = 0;
      m_p1 = 0; m_p2 = 0; m_valid = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      if (s_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("sample_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_ph = e.ph;
          check("sample", int'(s_smpl), e.val);
          if (track) begin
            n_win++;
            track_one(int'(s_smpl), pk_d, zc_d, sg_d);
            track_one(e.val, pk_e, zc_e, sg_e);
          end
        end
      end
      m_acc = (m_valid != 0) && ready;
      if (m_p2 != 0) begin
        if (m_valid == 0 || ready) begin
          exp_q.push_back(m_v2);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_acc) begin
        m_valid = 0;
      end
      m_p2 = m_p1;
      m_v2 = m_v1;
      stb = (m_div == DIV - 1);
      m_div = stb ? 0 : m_div + 1;
      pa = m_pend | int'(s_kp);
      if (stb) begin
        m_pend = 0;
        case (m_st)
          0: begin m_env = 0; if (pa != 0) m_st = 1; end
          1: if (pa != 0) m_st = 3; else begin m_env++; if (m_env == RAMP) m_st = 2; end
          2: begin m_env = RAMP; if (pa != 0) m_st = 3; end
          default: if (pa != 0) m_st = 1; else begin if (m_env > 0) m_env--; if (m_env == 0) m_st = 0; end
        endcase
        m_phase = (m_phase + FTW) % PMOD;
        m_v1.ph  = m_phase;
        m_v1.val = ref_val(m_phase, m_env);
        m_p1 = 1;
      end else begin
        m_p1 = 0;
        if (s_kp) m_pend = 1;
      end
    end
    #1;
    s_valid = valid;
    s_smpl  = smpl;
    s_kp    = kp;
    n_kp   += int'(kp);
    check("valid", int'(valid), m_valid);
    check("playing", int'(playing), int'(m_st != 0));
    check("overrun", int'(ovr), m_ovr);
  endtask

  task automatic press();
    key = 1'b0;
    repeat (20) tick();
    key = 1'b1;
    repeat (40) tick();
  endtask

  task automatic wait_playing(input logic lvl, input int budget, input string nm);
    int t;
    t = 0;
    while (playing !== lvl && t < budget) begin
      tick();
      t++;
    end
    check(nm, int'(playing), int'(lvl));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    deb_vec_t dv [4];
    int t, held, bp_ph;
    dv[0] = '{1, 0};
    dv[1] = '{10, 0};
    dv[2] = '{3, 0};
    dv[3] = '{20, 1};
    for (int i = 0; i < 256; i++)
      lut[i] = $rtoi($sin((real'(i) + 0.5) * 3.14159265358979323846 / 512.0) * 32767.0 + 0.5);

    rstn = 1'b0;
    repeat (3) tick();
    check("rst_smpl", int'(smpl), 0);
    check("rst_keypress", int'(kp), 0);

    rstn = 1'b1;
    t = 0;
    while (!valid && t < 50) begin tick(); t++; end
    check("first_valid_clk", t, 10);
    check("idle_smpl", int'(smpl), 0);
    t = 0;
    do begin tick(); t++; end while (!valid && t < 50);
    check("stb_period", t, DIV);
    repeat (20) tick();

    for (int i = 0; i < 4; i++) begin
      n_kp = 0;
      key = 1'b0;
      repeat (dv[i].low_clks) tick();
      key = 1'b1;
      repeat (40) tick();
      check("deb_press", n_kp, dv[i].exp_press);
    end

    repeat (RAMP * DIV + 40) tick();
    check("ramp_playing", int'(playing), 1);

    track = 1'b1;
    n_win = 0; pk_d = 0; pk_e = 0; zc_d = 0; zc_e = 0; sg_d = 0; sg_e = 0;
    repeat (300 * DIV) tick();
    track = 1'b0;
    check("tone_samples", n_win, 300);
    check("tone_peak", pk_d, pk_e);
    check("tone_zero_cross", zc_d, zc_e);

    ready = 1'b0;
    t = 0;
    while (!valid && t < 40) begin tick(); t++; end
    held = int'(smpl);
    repeat (2 * DIV) tick();
    check("bp_hold", int'(smpl), held);
    check("bp_overrun", int'(ovr), 1);
    ready = 1'b1;
    tick();
    bp_ph = last_ph;
    t = 0;
    while (!valid && t < 40) begin tick(); t++; end
    check("bp_next_sample", int'(smpl), ref_val((bp_ph + 3 * FTW) % PMOD, RAMP));

    press();
    wait_playing(1'b0, 3000, "play_fade_to_mute");
    press();
    t = 0;
    while (!(m_st == 1 && m_env >= 97) && t < 3000) begin tick(); t++; end
    press();
    check("rev_fade_dn", m_st, 3);
    wait_playing(1'b0, 2000, "rev_fade_to_mute");
    repeat (3 * DIV) tick();
    check("mute_smpl", int'(smpl), 0);

    press();
    repeat (50 * DIV) tick();
    press();
    repeat (10 * DIV) tick();
    check("pre_rst_playing", int'(playing), 1);
    rstn = 1'b0;
    tick();
    check("midfade_rst_valid", int'(valid), 0);
    check("midfade_rst_playing", int'(playing), 0);
    check("midfade_rst_ovr", int'(ovr), 0);
    check("midfade_rst_smpl", int'(smpl), 0);
    rstn = 1'b1;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
